// File: rtl/clk_div_pkg.sv
// Shared constants and types for the clk_div_gen clock divider.
//   NUM_CH_DEF  default channel count
//   CNT_W_DEF   default half-period width
//   EDGE_W_DEF  default rising-edge counter width
//   half_per_t  per-channel half-period value at the default width
//   ch_mode_e   per-channel operating mode (decoded each cycle, not stored)
package clk_div_pkg;

    localparam int unsigned NUM_CH_DEF = 2;
    localparam int unsigned CNT_W_DEF  = 8;
    localparam int unsigned EDGE_W_DEF = 16;

    typedef logic [CNT_W_DEF-1:0] half_per_t;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_mode_e;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: a shadowed half-period that is adopted only at a
// half-period boundary, so reprogramming never produces a short pulse.
// Optional rising-edge counter under macro CLK_DIV_EDGE_CNT_EN.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   en             run enable
//   load           write half_per into the shadow register
//   half_per       new half-period value
//   cnt_clr        clear edge counter (CLK_DIV_EDGE_CNT_EN only)
//   edge_cnt       saturating rise count (CLK_DIV_EDGE_CNT_EN only)
//   clk_out        registered divided clock
//   rise           one-cycle pulse when clk_out goes 0->1
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF
`ifdef CLK_DIV_EDGE_CNT_EN
    ,
    parameter int unsigned EDGE_W = EDGE_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [CNT_W-1:0]  half_per,
`ifdef CLK_DIV_EDGE_CNT_EN
    input  logic              cnt_clr,
    output logic [EDGE_W-1:0] edge_cnt,
`endif
    output logic              clk_out,
    output logic              rise
);

    logic [CNT_W-1:0] hs_q, hs_d;
    logic [CNT_W-1:0] ha_q, ha_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             rise_q, rise_d;
    ch_mode_e         mode_c;

    // Mode decode, phase counter and boundary handling.
    always_comb begin
        hs_d      = load ? half_per : hs_q;
        ha_d      = hs_q;
        cnt_d     = '0;
        clk_out_d = 1'b0;
        rise_d    = 1'b0;
        mode_c    = (en && (ha_q != '0)) ? CH_RUN : CH_IDLE;

        unique case (mode_c)
            CH_IDLE: begin
                // Track the shadow so a later enable starts with the latest value.
                ha_d = hs_q;
            end
            CH_RUN: begin
                ha_d      = ha_q;
                cnt_d     = cnt_q + CNT_W'(1);
                clk_out_d = clk_out_q;
                if (cnt_q == ha_q - CNT_W'(1)) begin
                    cnt_d     = '0;
                    clk_out_d = ~clk_out_q;
                    // A load landing on the boundary takes effect immediately.
                    ha_d      = load ? half_per : hs_q;
                end
            end
            default: ;
        endcase

        rise_d = clk_out_d & ~clk_out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q      <= '0;
            ha_q      <= '0;
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            rise_q    <= 1'b0;
        end else begin
            hs_q      <= hs_d;
            ha_q      <= ha_d;
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            rise_q    <= rise_d;
        end
    end

    assign clk_out = clk_out_q;
    assign rise    = rise_q;

`ifdef CLK_DIV_EDGE_CNT_EN
    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;

    // Counts visible rise pulses; clear beats a coincident rise; saturates.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if (cnt_clr) begin
            edge_cnt_d = '0;
        end else if (rise_q && (edge_cnt_q != '1)) begin
            edge_cnt_d = edge_cnt_q + EDGE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt_q <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
`endif

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel glitch-free programmable clock divider.
// Optional per-channel rising-edge counters under macro CLK_DIV_EDGE_CNT_EN.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   en[i]          channel run enable
//   load[i]        write half_per slice i into channel i's shadow register
//   half_per       packed half-periods, channel i at [i*CNT_W +: CNT_W]
//   cnt_clr[i]     clear edge counter i (CLK_DIV_EDGE_CNT_EN only)
//   edge_cnt       packed edge counts, channel i at [i*EDGE_W +: EDGE_W]
//                  (CLK_DIV_EDGE_CNT_EN only)
//   clk_out[i]     registered divided clock of channel i
//   rise[i]        one-cycle pulse when clk_out[i] goes 0->1
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned EDGE_W = EDGE_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        en,
    input  logic [NUM_CH-1:0]        load,
    input  logic [NUM_CH*CNT_W-1:0]  half_per,
`ifdef CLK_DIV_EDGE_CNT_EN
    input  logic [NUM_CH-1:0]        cnt_clr,
    output logic [NUM_CH*EDGE_W-1:0] edge_cnt,
`endif
    output logic [NUM_CH-1:0]        clk_out,
    output logic [NUM_CH-1:0]        rise
);

    // Elaboration-time range guard on the configuration.
    if ((NUM_CH < 1) || (NUM_CH > 16) || (CNT_W < 1) || (EDGE_W < 1)) begin : g_param_chk
        $error("clk_div_gen: parameter out of range");
    end

    // Fully independent channels.
    for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
        clk_div_ch #(
            .CNT_W    (CNT_W)
`ifdef CLK_DIV_EDGE_CNT_EN
            ,
            .EDGE_W   (EDGE_W)
`endif
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en[i]),
            .load     (load[i]),
            .half_per (half_per[i*CNT_W +: CNT_W]),
`ifdef CLK_DIV_EDGE_CNT_EN
            .cnt_clr  (cnt_clr[i]),
            .edge_cnt (edge_cnt[i*EDGE_W +: EDGE_W]),
`endif
            .clk_out  (clk_out[i]),
            .rise     (rise[i])
        );
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen (2 channels, 8-bit half-periods).
// With CLK_DIV_EDGE_CNT_EN defined the edge counters are built with EDGE_W=4.
module tb_clk_div_gen;
    import clk_div_pkg::*;

    localparam int unsigned NCH = 2;
    localparam int unsigned CW  = 8;
`ifdef CLK_DIV_EDGE_CNT_EN
    localparam int unsigned EW  = 4;
`else
    localparam int unsigned EW  = 16;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [NCH-1:0]     en;
    logic [NCH-1:0]     load;
    logic [NCH*CW-1:0]  half_per;
    logic [NCH-1:0]     clk_out;
    logic [NCH-1:0]     rise;
`ifdef CLK_DIV_EDGE_CNT_EN
    logic [NCH-1:0]     cnt_clr;
    logic [NCH*EW-1:0]  edge_cnt;
`endif

    always #5 clk = ~clk;

    clk_div_gen #(
        .NUM_CH   (NCH),
        .CNT_W    (CW),
        .EDGE_W   (EW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .half_per (half_per),
`ifdef CLK_DIV_EDGE_CNT_EN
        .cnt_clr  (cnt_clr),
        .edge_cnt (edge_cnt),
`endif
        .clk_out  (clk_out),
        .rise     (rise)
    );

    // One cycle of stimulus and the outputs required after the next edge.
    typedef struct {
        logic           rst;
        logic [NCH-1:0] en;
        logic [NCH-1:0] load;
        logic [NCH*CW-1:0] hp;
        logic [NCH-1:0] clr;
        logic [NCH-1:0] exp_clk;
        logic [NCH-1:0] exp_rise;
        string          name;
    } vec_t;

    typedef struct {
        logic [NCH-1:0] clk;
        logic [NCH-1:0] rise;
        string          name;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic r, input logic [NCH-1:0] e,
                                input logic [NCH-1:0] l, input logic [NCH*CW-1:0] h,
                                input logic [NCH-1:0] ec, input logic [NCH-1:0] er,
                                input string n, input logic [NCH-1:0] c = '0);
        vec_t v;
        v.rst = r; v.en = e; v.load = l; v.hp = h; v.clr = c;
        v.exp_clk = ec; v.exp_rise = er; v.name = n;
        return v;
    endfunction

    // Drive, push the expectation, clock once, pop and compare.
    task automatic apply(input vec_t v);
        exp_t e;
        rst      = v.rst;
        en       = v.en;
        load     = v.load;
        half_per = v.hp;
`ifdef CLK_DIV_EDGE_CNT_EN
        cnt_clr  = v.clr;
`endif
        exp_q.push_back('{clk: v.exp_clk, rise: v.exp_rise, name: v.name});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_tests++;
        if (clk_out !== e.clk) begin
            n_fail++;
            $display("FAIL %s clk_out got %b expected %b", e.name, clk_out, e.clk);
        end
        n_tests++;
        if (rise !== e.rise) begin
            n_fail++;
            $display("FAIL %s rise got %b expected %b", e.name, rise, e.rise);
        end
    endtask

`ifdef CLK_DIV_EDGE_CNT_EN
    task automatic check_edge(input logic [NCH*EW-1:0] exp, input string n);
        n_tests++;
        if (edge_cnt !== exp) begin
            n_fail++;
            $display("FAIL %s edge_cnt got %h expected %h", n, edge_cnt, exp);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; en = '0; load = '0; half_per = '0;
`ifdef CLK_DIV_EDGE_CNT_EN
        cnt_clr = '0;
`endif

        // Reset state.
        vecs.push_back(mk(1, 2'b00, 2'b00, '0, 2'b00, 2'b00, "reset0"));
        vecs.push_back(mk(1, 2'b00, 2'b00, '0, 2'b00, 2'b00, "reset1"));

        // ch0 H=1 (50 MHz), ch1 H=2 (25 MHz); k counts edges since enable.
        vecs.push_back(mk(0, 2'b00, 2'b11, {8'd2, 8'd1}, 2'b00, 2'b00, "a_load"));
        vecs.push_back(mk(0, 2'b00, 2'b00, '0, 2'b00, 2'b00, "a_idle"));
        for (int k = 1; k <= 10; k++) begin
            logic c0, c1, r0, r1;
            c0 = (k % 2) == 1;
            r0 = c0;
            c1 = ((k / 2) % 2) == 1;
            r1 = (k % 4) == 2;
            vecs.push_back(mk(0, 2'b11, 2'b00, '0, {c1, c0}, {r1, r0},
                              $sformatf("a_run_k%0d", k)));
        end

        // ch0 H=3, load H=5 mid low phase: low lasts 3, then 5-cycle halves.
        vecs.push_back(mk(1, 2'b00, 2'b00, '0, 2'b00, 2'b00, "b_reset"));
        vecs.push_back(mk(0, 2'b00, 2'b01, {8'd0, 8'd3}, 2'b00, 2'b00, "b_load"));
        vecs.push_back(mk(0, 2'b00, 2'b00, '0, 2'b00, 2'b00, "b_idle"));
        for (int k = 1; k <= 14; k++) begin
            logic c0, r0;
            c0 = (k >= 3) && ((((k - 3) / 5) % 2) == 0);
            r0 = (k >= 3) && (((k - 3) % 10) == 0);
            vecs.push_back(mk(0, 2'b01, (k == 2) ? 2'b01 : 2'b00, {8'd0, 8'd5},
                              {1'b0, c0}, {1'b0, r0}, $sformatf("b_run_k%0d", k)));
        end

        // ch0 H=3, load H=4 exactly on the first boundary: high lasts 4.
        vecs.push_back(mk(1, 2'b00, 2'b00, '0, 2'b00, 2'b00, "c_reset"));
        vecs.push_back(mk(0, 2'b00, 2'b01, {8'd0, 8'd3}, 2'b00, 2'b00, "c_load"));
        vecs.push_back(mk(0, 2'b00, 2'b00, '0, 2'b00, 2'b00, "c_idle"));
        for (int k = 1; k <= 12; k++) begin
            logic c0, r0;
            c0 = (k >= 3) && ((((k - 3) / 4) % 2) == 0);
            r0 = (k >= 3) && (((k - 3) % 8) == 0);
            vecs.push_back(mk(0, 2'b01, (k == 3) ? 2'b01 : 2'b00, {8'd0, 8'd4},
                              {1'b0, c0}, {1'b0, r0}, $sformatf("c_run_k%0d", k)));
        end

        // ch1 H=2 disabled while high, then re-enabled; ch0 H=1 undisturbed.
        vecs.push_back(mk(1, 2'b00, 2'b00, '0, 2'b00, 2'b00, "d_reset"));
        vecs.push_back(mk(0, 2'b00, 2'b11, {8'd2, 8'd1}, 2'b00, 2'b00, "d_load"));
        vecs.push_back(mk(0, 2'b00, 2'b00, '0, 2'b00, 2'b00, "d_idle"));
        for (int t = 1; t <= 12; t++) begin
            logic c0, c1, r1;
            int   k1;
            c0 = (t % 2) == 1;
            k1 = (t <= 2) ? t : ((t <= 5) ? 0 : t - 5);
            c1 = (k1 > 0) && (((k1 / 2) % 2) == 1);
            r1 = (k1 > 0) && ((k1 % 4) == 2);
            vecs.push_back(mk(0, ((t >= 3) && (t <= 5)) ? 2'b01 : 2'b11, 2'b00, '0,
                              {c1, c0}, {r1, c0}, $sformatf("d_run_t%0d", t)));
        end

        foreach (vecs[i]) apply(vecs[i]);

        // Reset mid-run overrides load/en; zero shadow keeps channels idle.
        apply(mk(1, 2'b11, 2'b11, {8'd5, 8'd5}, 2'b00, 2'b00, "e_rst_mid"));
        for (int i = 0; i < 4; i++)
            apply(mk(0, 2'b11, 2'b00, '0, 2'b00, 2'b00, $sformatf("e_hold%0d", i)));
        apply(mk(0, 2'b11, 2'b01, {8'd0, 8'd1}, 2'b00, 2'b00, "e_load"));
        apply(mk(0, 2'b11, 2'b00, '0, 2'b00, 2'b00, "e_idle"));
        apply(mk(0, 2'b11, 2'b00, '0, 2'b01, 2'b01, "e_first_rise"));
        apply(mk(0, 2'b11, 2'b00, '0, 2'b00, 2'b00, "e_fall"));

`ifdef CLK_DIV_EDGE_CNT_EN
        // Edge counter: saturation at 15 and clear beating a coincident rise.
        apply(mk(1, 2'b00, 2'b00, '0, 2'b00, 2'b00, "f_reset"));
        check_edge('0, "f_reset_cnt");
        apply(mk(0, 2'b00, 2'b01, {8'd0, 8'd1}, 2'b00, 2'b00, "f_load"));
        apply(mk(0, 2'b00, 2'b00, '0, 2'b00, 2'b00, "f_idle"));
        for (int k = 1; k <= 40; k++) begin
            logic c0;
            c0 = (k % 2) == 1;
            apply(mk(0, 2'b01, 2'b00, '0, {1'b0, c0}, {1'b0, c0}, $sformatf("f_run_k%0d", k)));
        end
        check_edge({4'd0, 4'd15}, "f_saturate");
        apply(mk(0, 2'b01, 2'b00, '0, 2'b01, 2'b01, "f_k41"));
        apply(mk(0, 2'b01, 2'b00, '0, 2'b00, 2'b00, "f_k42_clr", 2'b01));
        check_edge('0, "f_clr_wins");
        apply(mk(0, 2'b01, 2'b00, '0, 2'b01, 2'b01, "f_k43"));
        apply(mk(0, 2'b01, 2'b00, '0, 2'b00, 2'b00, "f_k44"));
        check_edge({4'd0, 4'd1}, "f_recount");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
